// File: rtl/filter_2.sv
// Streaming 3x3 sharpen filter: WEIGHT*C - (N+S+E+W), clamped, with two line memories.
// Optional macro FILTER_BORDER_ZERO_EN forces border pixels to 0 instead of passthrough.
module filter_2 #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned WIDTH_IMAG  = 384,
   parameter int unsigned HEIGHT_IMAG = 512,
   parameter int unsigned WEIGHT      = 5
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  i_hav,
   input  logic                  i_vav,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  wr_file
);

   localparam int unsigned SW = DATA_WIDTH + 6;
   localparam int unsigned CW = $clog2(WIDTH_IMAG);
   localparam int unsigned RW = $clog2(HEIGHT_IMAG);
   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH_IMAG - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT_IMAG - 1);
   localparam logic signed [SW-1:0] MAXV = SW'((1 << DATA_WIDTH) - 1);

   typedef enum logic {S_RUN, S_FLUSH} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   col_q, col_d;
   logic [RW-1:0]   row_q, row_d;
   logic [CW-1:0]   fcol_q, fcol_d;
   logic [CW-1:0]   e_idx;
   logic            accept;
   logic            last_px;
   logic            flush_rd;

   // mem_a holds the most recent complete row, mem_b the one before it
   logic [DATA_WIDTH-1:0] mem_a [WIDTH_IMAG];
   logic [DATA_WIDTH-1:0] mem_b [WIDTH_IMAG];
   logic [DATA_WIDTH-1:0] prev_c_q;

   logic                  v1_q, v1_d, b1_q, b1_d;
   logic [DATA_WIDTH-1:0] n1_q, n1_d, c1_q, c1_d, e1_q, e1_d, s1_q, s1_d, w1_q, w1_d;
   logic                  v2_q, b2_q, v3_q, b3_q;
   logic [DATA_WIDTH-1:0] bp2_q, bp2_d, bp3_q;
   logic signed [SW-1:0]  wc2_q, nb2_q, sum3_q;
   logic [DATA_WIDTH-1:0] pix_d;

   assign accept  = i_hav & i_vav;
   assign last_px = accept && (col_q == COL_LAST) && (row_q == ROW_LAST);
   assign e_idx   = (col_q == COL_LAST) ? col_q : col_q + 1'b1;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (!i_vav) begin
         col_d = '0;
         row_d = '0;
      end else if (i_hav) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      fcol_d   = fcol_q;
      flush_rd = 1'b0;
      case (state_q)
         S_RUN: begin
            if (last_px) begin
               state_d = S_FLUSH;
               fcol_d  = '0;
            end
         end
         S_FLUSH: begin
            flush_rd = 1'b1;
            if (fcol_q == COL_LAST) state_d = S_RUN;
            else                    fcol_d  = fcol_q + 1'b1;
         end
         default: state_d = S_RUN;
      endcase
   end

   // Accepting (r+1,c) centres the window on (r,c): E is still row r in mem_a,
   // W is the centre captured on the previous accept.
   always_comb begin
      v1_d = 1'b0;
      b1_d = 1'b1;
      n1_d = mem_b[col_q];
      c1_d = mem_a[col_q];
      e1_d = mem_a[e_idx];
      s1_d = data_in;
      w1_d = prev_c_q;
      if (flush_rd) begin
         v1_d = 1'b1;
         c1_d = mem_a[fcol_q];
      end else if (accept && (row_q != '0)) begin
         v1_d = 1'b1;
         b1_d = (row_q == RW'(1)) || (col_q == '0) || (col_q == COL_LAST);
      end
   end

   always_comb begin
`ifdef FILTER_BORDER_ZERO_EN
      bp2_d = '0;
`else
      bp2_d = c1_q;
`endif
   end

   always_comb begin
      pix_d = data_out;
      if (v3_q) begin
         if (b3_q)                pix_d = bp3_q;
         else if (sum3_q < 0)     pix_d = '0;
         else if (sum3_q > MAXV)  pix_d = '1;
         else                     pix_d = sum3_q[DATA_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         mem_b[col_q] <= mem_a[col_q];
         mem_a[col_q] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         state_q  <= S_RUN;
         col_q    <= '0;
         row_q    <= '0;
         fcol_q   <= '0;
         prev_c_q <= '0;
         v1_q     <= 1'b0;
         b1_q     <= 1'b0;
         n1_q     <= '0;
         c1_q     <= '0;
         e1_q     <= '0;
         s1_q     <= '0;
         w1_q     <= '0;
         v2_q     <= 1'b0;
         b2_q     <= 1'b0;
         bp2_q    <= '0;
         wc2_q    <= '0;
         nb2_q    <= '0;
         v3_q     <= 1'b0;
         b3_q     <= 1'b0;
         bp3_q    <= '0;
         sum3_q   <= '0;
         data_out <= '0;
         wr_file  <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         fcol_q   <= fcol_d;
         if (accept) prev_c_q <= mem_a[col_q];
         v1_q     <= v1_d;
         b1_q     <= b1_d;
         n1_q     <= n1_d;
         c1_q     <= c1_d;
         e1_q     <= e1_d;
         s1_q     <= s1_d;
         w1_q     <= w1_d;
         v2_q     <= v1_q;
         b2_q     <= b1_q;
         bp2_q    <= bp2_d;
         wc2_q    <= SW'(WEIGHT) * SW'(c1_q);
         nb2_q    <= SW'(n1_q) + SW'(s1_q) + SW'(e1_q) + SW'(w1_q);
         v3_q     <= v2_q;
         b3_q     <= b2_q;
         bp3_q    <= bp2_q;
         sum3_q   <= wc2_q - nb2_q;
         data_out <= pix_d;
         wr_file  <= v3_q;
      end
   end

endmodule

// File: tb/tb_filter_2.sv
// Self-checking bench for filter_2 (W=8, H=4): array reference model with output timing.
module tb_filter_2;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int DW = 8;
   localparam int WT = 5;

   logic          clk = 1'b0;
   logic          rstb, i_hav, i_vav;
   logic [DW-1:0] data_in, data_out;
   logic          wr_file;

   always #5 clk = ~clk;

   filter_2 #(.DATA_WIDTH(DW), .WIDTH_IMAG(W), .HEIGHT_IMAG(H), .WEIGHT(WT)) dut (
      .clk(clk), .rstb(rstb), .i_hav(i_hav), .i_vav(i_vav),
      .data_in(data_in), .data_out(data_out), .wr_file(wr_file)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int out_val[$], out_cyc[$], exp_val[$], exp_cyc[$];
   int px[H][W];
   int acc[H][W];
   int tests = 0, fails = 0;

   always @(negedge clk) begin
      if (wr_file === 1'b1) begin
         out_val.push_back(int'(data_out));
         out_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      tests++;
      assert (got === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
      end
   endtask

   function automatic bit is_border(int r, int c);
      return (r == 0) || (r == H-1) || (c == 0) || (c == W-1);
   endfunction

   function automatic int ref_pix(int r, int c);
      int s;
      if (is_border(r, c)) begin
`ifdef FILTER_BORDER_ZERO_EN
         return 0;
`else
         return px[r][c];
`endif
      end
      s = WT*px[r][c] - px[r-1][c] - px[r+1][c] - px[r][c-1] - px[r][c+1];
      if (s < 0) return 0;
      if (s > (1 << DW) - 1) return (1 << DW) - 1;
      return s;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         i_hav = 1'b0;
         i_vav = 1'b0;
      end
   endtask

   // Drives up to npix pixels of px[][] in raster order with random intra-line gaps.
   task automatic drive_frame(input int gap_max, input int npix);
      int k = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (k == npix) return;
            repeat ($urandom_range(gap_max, 0)) begin
               @(negedge clk);
               i_vav = 1'b1;
               i_hav = 1'b0;
            end
            @(negedge clk);
            i_vav   = 1'b1;
            i_hav   = 1'b1;
            data_in = DW'(px[r][c]);
            acc[r][c] = cyc + 1;
            k++;
         end
         if (r != H-1) begin
            repeat (2) begin
               @(negedge clk);
               i_hav = 1'b0;
            end
         end
      end
   endtask

   task automatic add_expected();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            exp_val.push_back(ref_pix(r, c));
            exp_cyc.push_back((r < H-1) ? acc[r+1][c] + 3 : acc[H-1][W-1] + 4 + c);
         end
   endtask

   task automatic compare(input string tag);
      int n;
      chk({tag, "_count"}, out_val.size(), exp_val.size());
      n = (out_val.size() < exp_val.size()) ? out_val.size() : exp_val.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_val[%0d]", tag, i), out_val[i], exp_val[i]);
         chk($sformatf("%s_cyc[%0d]", tag, i), out_cyc[i], exp_cyc[i]);
      end
      out_val.delete(); out_cyc.delete(); exp_val.delete(); exp_cyc.delete();
   endtask

   task automatic fill_rand();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) px[r][c] = $urandom_range(255, 0);
   endtask

   initial begin
      int n100;
      rstb = 1'b1; i_hav = 1'b0; i_vav = 1'b0; data_in = '0;
      repeat (3) @(negedge clk);
      chk("reset_data_out", data_out, 0);
      chk("reset_wr_file", wr_file, 0);
      rstb = 1'b0;
      idle(3);

      // flat frame
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) px[r][c] = 100;
      drive_frame(0, W*H);
      idle(W + 10);
      n100 = 0;
      foreach (out_val[i]) if (out_val[i] == 100) n100++;
`ifdef FILTER_BORDER_ZERO_EN
      chk("flat_n100", n100, 12);
`else
      chk("flat_n100", n100, 32);
`endif
      add_expected();
      compare("flat");

      // single impulse
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) px[r][c] = 0;
      px[1][3] = 200;
      drive_frame(1, W*H);
      idle(W + 10);
      chk("imp_1_3", out_val[11], 255);
      chk("imp_0_3", out_val[3], 0);
      chk("imp_1_2", out_val[10], 0);
      chk("imp_1_4", out_val[12], 0);
      chk("imp_2_3", out_val[19], 0);
      add_expected();
      compare("imp");

      // gradient col*10
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) px[r][c] = c * 10;
      drive_frame(2, W*H);
      idle(W + 10);
      for (int r = 1; r < H-1; r++)
         for (int c = 1; c < W-1; c++)
            chk($sformatf("grad_%0d_%0d", r, c), out_val[r*W + c], c * 10);
      chk("grad_first_cyc", out_cyc[0], acc[1][0] + 3);
      chk("grad_flush_cyc", out_cyc[(H-1)*W], acc[H-1][W-1] + 4);
      add_expected();
      compare("grad");

      // random frames separated by minimum vertical blanking
      for (int f = 0; f < 3; f++) begin
         fill_rand();
         drive_frame(3, W*H);
         add_expected();
         idle(W + 4);
      end
      idle(10);
      compare("rand_tight");

      // reset mid row 2, then restart
      fill_rand();
      drive_frame(0, 2*W + 3);
      @(negedge clk);
      i_hav = 1'b0;
      rstb  = 1'b1;
      #1;
      chk("midrst_wr_file", wr_file, 0);
      chk("midrst_data_out", data_out, 0);
      out_val.delete(); out_cyc.delete();
      @(negedge clk);
      rstb  = 1'b0;
      i_vav = 1'b0;
      idle(5);
      chk("midrst_no_out", out_val.size(), 0);
      fill_rand();
      drive_frame(1, W*H);
      idle(W + 10);
      add_expected();
      compare("restart");

      // two frames with 51-line blanking
      for (int f = 0; f < 2; f++) begin
         fill_rand();
         drive_frame(0, W*H);
         add_expected();
         idle(51 * (W + 2));
      end
      compare("b2b");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/filter_2.md
Name: filter_2

Overview:
- Streaming 3x3-neighbourhood sharpening filter for a raster video stream, e.g. the 8-bit gray output of the rgb2gray stage.
- Buffers pixel rows internally in on-chip line memory and computes WEIGHT*C - (N+S+E+W) per pixel, clamped to the DATA_WIDTH range.
- Emits exactly one output pixel per input pixel, in raster order, each qualified by a write strobe for the downstream file/memory writer.

Parameters:
- DATA_WIDTH, 8, pixel bit width (in and out).
- WIDTH_IMAG, 384, active pixels per line (>=3).
- HEIGHT_IMAG, 512, active lines per frame (>=3).
- WEIGHT, 5, centre tap weight, legal range 1..15; 5 gives a unity-gain Laplacian sharpen.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rstb  input  1  asynchronous reset, active-high (the codebase keeps the name rstb).
- i_hav  input  1  horizontal active.
- i_vav  input  1  vertical active; a pixel is accepted on a cycle with i_hav & i_vav.
- data_in  input  DATA_WIDTH  input pixel, unsigned.
- data_out  output  DATA_WIDTH  filtered pixel, unsigned.
- wr_file  output  1  one-cycle strobe; data_out is valid while high.

Behaviour:
- Reset (asynchronous, rstb=1) clears data_out=0, wr_file=0, the column/row counters and the flush state.
  - Line memory contents are don't-care after reset.
  - Reset mid-frame abandons the frame; the next accepted pixel after i_vav low counts as pixel (0,0).
- Counters: col 0..WIDTH_IMAG-1 and row 0..HEIGHT_IMAG-1 advance on each accepted pixel.
  - col wraps to 0 and row increments at end of line.
  - While i_vav=0 both counters are held at 0.
- Line memory holds the two most recent complete rows, depth WIDTH_IMAG each; no read/write collision stalls are allowed.
- Output of pixel (r,c), r <= HEIGHT_IMAG-2: emitted with wr_file=1 exactly 3 clocks after input pixel (r+1,c) is accepted.
  - No output is produced while row 0 is being received.
- Last row flush: row HEIGHT_IMAG-1 is emitted autonomously.
  - WIDTH_IMAG consecutive cycles, wr_file=1 on each.
  - Starts 4 clocks after the final pixel (HEIGHT_IMAG-1, WIDTH_IMAG-1) is accepted, so it is contiguous with output (HEIGHT_IMAG-2, WIDTH_IMAG-1).
  - The flush is independent of i_hav/i_vav.
  - Input accepted during the flush belongs to the next frame and must not corrupt it. This requires vertical blanking >= WIDTH_IMAG+4 cycles, which the upstream sync generator guarantees.
- Total: exactly WIDTH_IMAG*HEIGHT_IMAG wr_file pulses per frame, raster order.
- Interior pixels (0<r<H-1, 0<c<W-1):
  - s = WEIGHT*C - N - S - W - E, computed as signed, DATA_WIDTH+6 bits wide.
  - data_out = 0 if s<0; 2^DATA_WIDTH-1 if s > max; else s.
- Border pixels (r=0, r=H-1, c=0, c=W-1): data_out = C unchanged.
- When wr_file=0, data_out holds its last value.

Optional Feature:
- Macro FILTER_BORDER_ZERO_EN.
- Defined: border pixels output 0 instead of the passthrough value; timing and count are unchanged.
- Undefined: border passthrough as specified above.

Test Plan:
- W=8, H=4, WEIGHT=5, flat frame all 100 -> 32 wr_file pulses, every data_out=100.
- Single 200 at (1,3) in a 0 frame:
  - data_out(1,3)=255 (1000 clamped);
  - (0,3)=0 (border);
  - (1,2)=(1,4)=(2,3)=0 (negative clamped).
- Gradient data_in=col*10 -> interior outputs equal col*10; first output appears 3 clocks after input (1,0); flush of row 3 starts 4 clocks after input (3,7).
- Assert rstb for 1 cycle mid-row 2, then restart the frame -> wr_file low immediately, 32 outputs for the restarted frame, none from the aborted one.
- Two back-to-back frames with 51-line blanking -> 64 outputs total, second frame unaffected by the first flush.
- With FILTER_BORDER_ZERO_EN, flat 100 frame -> 20 border outputs = 0, 12 interior outputs = 100.
